// File: rtl/detector_borda_pkg.sv
// -----------------------------------------------------------------------------
// detector_borda_pkg
// Shared constants and helpers for the multi-channel edge detector.
//   MODO_*            : per-channel 2-bit mode encodings
//   evento_habilitado : decides whether a classified edge is enabled by a mode
// -----------------------------------------------------------------------------
package detector_borda_pkg;

    localparam logic [1:0] MODO_OFF     = 2'b00;
    localparam logic [1:0] MODO_SUBIDA  = 2'b01;
    localparam logic [1:0] MODO_DESCIDA = 2'b10;
    localparam logic [1:0] MODO_AMBAS   = 2'b11;

    function automatic logic evento_habilitado(input logic [1:0] modo,
                                               input logic       subida,
                                               input logic       descida);
        logic ev;
        case (modo)
            MODO_SUBIDA:  ev = subida;
            MODO_DESCIDA: ev = descida;
            MODO_AMBAS:   ev = subida | descida;
            default:      ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/canal_debounce.sv
// -----------------------------------------------------------------------------
// canal_debounce
// One channel: synchroniser chain, debounce counter, stable level register and
// edge classification.
//   clk_i, rst_i : clock, synchronous active-high reset
//   entrada_i    : asynchronous raw input
//   subida_o     : high in the cycle before nivel_o goes 0->1 (next-state strobe)
//   descida_o    : high in the cycle before nivel_o goes 1->0 (next-state strobe)
//   nivel_o      : debounced stable level
// The strobes are combinational so the top level can register the event pulse
// on the very same edge that updates nivel_o.
// -----------------------------------------------------------------------------
module canal_debounce
    import detector_borda_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic entrada_i,
    output logic subida_o,
    output logic descida_o,
    output logic nivel_o
);

    localparam int             CW      = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   nivel_q, nivel_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   aceita;

    always_comb begin
        sync_s = sync_q[SYNC_STAGES-1];
        // A new level is accepted on the DEBOUNCE-th consecutive mismatch.
        aceita = (sync_s != nivel_q) && (cnt_q == CNT_MAX);
        nivel_d = aceita ? sync_s : nivel_q;

        if (sync_s == nivel_q || aceita)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);

        subida_o  = aceita &  sync_s;
        descida_o = aceita & ~sync_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            nivel_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], entrada_i};
            nivel_q <= nivel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nivel_o = nivel_q;

endmodule

// File: rtl/detector_borda_multicanal.sv
// -----------------------------------------------------------------------------
// detector_borda_multicanal
// Multi-channel synchronised, debounced edge detector with sticky pending flags,
// overflow tracking and a summary interrupt.
//   clk, rst  : clock, synchronous active-high reset
//   entrada   : [CANAIS]   asynchronous raw inputs
//   modo      : [2*CANAIS] per-channel mode (00 off, 01 rise, 10 fall, 11 both)
//   ack       : [CANAIS]   write-1-to-clear for pendente/overflow
//   detector  : [CANAIS]   registered one-cycle event pulse
//   pendente  : [CANAIS]   sticky event flag
//   overflow  : [CANAIS]   event arrived while pendente was already set
//   nivel     : [CANAIS]   debounced stable level
//   irq       : OR of all pendente bits
// -----------------------------------------------------------------------------
module detector_borda_multicanal
    import detector_borda_pkg::*;
#(
    parameter int CANAIS      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CANAIS-1:0]     entrada,
    input  logic [2*CANAIS-1:0]   modo,
    input  logic [CANAIS-1:0]     ack,
    output logic [CANAIS-1:0]     detector,
    output logic [CANAIS-1:0]     pendente,
    output logic [CANAIS-1:0]     overflow,
    output logic [CANAIS-1:0]     nivel,
    output logic                  irq
);

    logic [CANAIS-1:0] subida_s, descida_s, ev_s;
    logic [CANAIS-1:0] detector_q;
    logic [CANAIS-1:0] pendente_q, pendente_d;
    logic [CANAIS-1:0] overflow_q, overflow_d;

    for (genvar g = 0; g < CANAIS; g++) begin : g_canal
        canal_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE)
        ) u_canal (
            .clk_i    (clk),
            .rst_i    (rst),
            .entrada_i(entrada[g]),
            .subida_o (subida_s[g]),
            .descida_o(descida_s[g]),
            .nivel_o  (nivel[g])
        );

        assign ev_s[g] = evento_habilitado(modo[2*g +: 2], subida_s[g], descida_s[g]);
    end

    // An event always wins pendente; ack in the same cycle only clears overflow.
    always_comb begin
        pendente_d = pendente_q;
        overflow_d = overflow_q;
        for (int i = 0; i < CANAIS; i++) begin
            if (ev_s[i]) begin
                pendente_d[i] = 1'b1;
                if (ack[i])
                    overflow_d[i] = 1'b0;
                else if (pendente_q[i])
                    overflow_d[i] = 1'b1;
            end else if (ack[i]) begin
                pendente_d[i] = 1'b0;
                overflow_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            detector_q <= '0;
            pendente_q <= '0;
            overflow_q <= '0;
        end else begin
            detector_q <= ev_s;
            pendente_q <= pendente_d;
            overflow_q <= overflow_d;
        end
    end

    assign detector = detector_q;
    assign pendente = pendente_q;
    assign overflow = overflow_q;
    assign irq      = |pendente_q;

endmodule

// File: tb/tb_detector_borda_multicanal.sv
module tb_detector_borda_multicanal;
    import detector_borda_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  entrada;
    logic [15:0] modo;
    logic [7:0]  ack;
    logic [7:0]  detector, pendente, overflow, nivel;
    logic        irq;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] seen;
    int         pulses3;

    always #5 clk = ~clk;

    detector_borda_multicanal #(
        .CANAIS(8), .SYNC_STAGES(2), .DEBOUNCE(4)
    ) dut (
        .clk(clk), .rst(rst), .entrada(entrada), .modo(modo), .ack(ack),
        .detector(detector), .pendente(pendente), .overflow(overflow),
        .nivel(nivel), .irq(irq)
    );

    // Advance one edge and sample 1ns later, accumulating detector activity.
    task automatic tick();
        @(posedge clk);
        #1;
        seen = seen | detector;
        if (detector[3]) pulses3++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; entrada = '0; modo = '0; ack = '0; seen = '0; pulses3 = 0;
        tick(); tick();
        chk("rst_detector", detector, 8'h00);
        chk("rst_pendente", pendente, 8'h00);
        chk("rst_overflow", overflow, 8'h00);
        chk("rst_nivel",    nivel,    8'h00);
        chk("rst_irq",      8'(irq),  8'h00);
        rst = 1'b0;

        // Clean rising edge on channel 0
        modo[1:0] = MODO_SUBIDA;
        entrada[0] = 1'b1;
        repeat (5) tick();
        chk("t1_det_early",   detector, 8'h00);
        chk("t1_nivel_early", nivel,    8'h00);
        tick();
        chk("t1_det",   detector, 8'h01);
        chk("t1_nivel", nivel,    8'h01);
        chk("t1_pend",  pendente, 8'h01);
        chk("t1_irq",   8'(irq),  8'h01);
        tick();
        chk("t1_det_one_cycle", detector, 8'h00);
        entrada[0] = 1'b0; seen = '0;
        repeat (10) tick();
        chk("t1_fall_no_event", seen,     8'h00);
        chk("t1_fall_nivel",    nivel,    8'h00);
        chk("t1_pend_sticky",   pendente, 8'h01);
        ack = 8'h01; tick(); ack = '0;
        chk("t1_ack_pend", pendente, 8'h00);
        chk("t1_ack_irq",  8'(irq),  8'h00);

        // Glitch rejection on channel 2
        modo[5:4] = MODO_SUBIDA;
        seen = '0;
        entrada[2] = 1'b1;
        repeat (3) tick();
        entrada[2] = 1'b0;
        repeat (12) tick();
        chk("t2_seen",  seen,     8'h00);
        chk("t2_nivel", nivel,    8'h00);
        chk("t2_pend",  pendente, 8'h00);

        // Both edges with overflow on channel 3
        modo[7:6] = MODO_AMBAS;
        pulses3 = 0;
        for (int k = 0; k < 4; k++) begin
            entrada[3] = ~entrada[3];
            repeat (10) tick();
            chk("t3_pulses",   8'(pulses3), 8'(k + 1));
            chk("t3_overflow", overflow,    (k >= 1) ? 8'h08 : 8'h00);
        end
        chk("t3_pend", pendente, 8'h08);
        ack = 8'h08; tick(); ack = '0;
        chk("t3_ack_pend", pendente, 8'h00);
        chk("t3_ack_ovf",  overflow, 8'h00);

        // Ack colliding with an event on channel 5
        modo[11:10] = MODO_SUBIDA;
        entrada[5] = 1'b1; repeat (10) tick();
        chk("t4_pend_first", pendente, 8'h20);
        chk("t4_ovf_first",  overflow, 8'h00);
        entrada[5] = 1'b0; repeat (10) tick();
        entrada[5] = 1'b1; repeat (10) tick();
        chk("t4_ovf_second", overflow, 8'h20);
        entrada[5] = 1'b0; repeat (10) tick();
        entrada[5] = 1'b1; repeat (5) tick();
        ack = 8'h20; tick(); ack = '0;
        chk("t4_coll_det",  detector, 8'h20);
        chk("t4_coll_pend", pendente, 8'h20);
        chk("t4_coll_ovf",  overflow, 8'h00);
        ack = 8'h20; tick(); ack = '0;
        chk("t4_lone_pend", pendente, 8'h00);
        chk("t4_lone_irq",  8'(irq),  8'h00);
        entrada[5] = 1'b0; repeat (10) tick();
        chk("t4_fall_pend", pendente, 8'h00);

        // Reset in the middle of a debounce on channel 1
        modo[3:2] = MODO_SUBIDA;
        entrada[1] = 1'b1;
        repeat (4) tick();
        rst = 1'b1; tick(); tick();
        chk("t5_rst_det",   detector, 8'h00);
        chk("t5_rst_nivel", nivel,    8'h00);
        chk("t5_rst_pend",  pendente, 8'h00);
        chk("t5_rst_ovf",   overflow, 8'h00);
        chk("t5_rst_irq",   8'(irq),  8'h00);
        rst = 1'b0;
        repeat (5) tick();
        chk("t5_det_early",   detector, 8'h00);
        chk("t5_nivel_early", nivel,    8'h00);
        tick();
        chk("t5_det",   detector, 8'h02);
        chk("t5_nivel", nivel,    8'h02);
        chk("t5_pend",  pendente, 8'h02);
        tick();
        chk("t5_det_one_cycle", detector, 8'h00);
        entrada[1] = 1'b0; repeat (10) tick();
        ack = 8'h02; tick(); ack = '0;
        chk("t5_ack_pend", pendente, 8'h00);

        // Mode off on every channel
        modo = '0; seen = '0;
        entrada = 8'hA5;
        repeat (5) tick();
        chk("t6_nivel_early", nivel, 8'h00);
        tick();
        chk("t6_nivel_a5", nivel, 8'hA5);
        entrada = 8'h5A; repeat (10) tick();
        chk("t6_nivel_5a", nivel, 8'h5A);
        entrada = 8'h00; repeat (10) tick();
        chk("t6_nivel_00", nivel,    8'h00);
        chk("t6_seen",     seen,     8'h00);
        chk("t6_pend",     pendente, 8'h00);
        chk("t6_irq",      8'(irq),  8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/detector_borda_multicanal.md
# detector_borda_multicanal

Parametrised, multi-channel successor to the team's two-bit rising-edge detector. Each channel synchronises an asynchronous input, debounces it, and detects rising, falling or both edges according to a per-channel mode. Detected events are flagged as one-cycle pulses and as sticky pending flags with acknowledge, overflow tracking and a summary interrupt. The block sits between raw board inputs (buttons, switches, external strobes) and the control logic or register bank that services them.

## Interface

- CANAIS, default 8: number of independent channels, ≥1.
- SYNC_STAGES, default 2: synchroniser flops per channel, ≥2.
- DEBOUNCE, default 4: consecutive mismatching samples required to accept a new level, ≥1; 1 means no filtering.

- clk  in  1  single clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- entrada  in  CANAIS  asynchronous raw inputs.
- modo  in  2*CANAIS  per-channel mode; bits [2i+1:2i] belong to channel i. 00 off, 01 rising, 10 falling, 11 both.
- ack  in  CANAIS  write-1-to-clear for pendente[i] and overflow[i]; sampled every cycle.
- detector  out  CANAIS  registered one-cycle event pulse per channel.
- pendente  out  CANAIS  sticky event flag per channel.
- overflow  out  CANAIS  sticky flag: event arrived while pendente[i] was already set.
- nivel  out  CANAIS  debounced stable level per channel.
- irq  out  1  OR of all pendente bits.

## Operation

- Reset (rst high at a clock edge): synchroniser flops, nivel, debounce counters, detector, pendente and overflow all go to 0, so irq = 0.
- Synchroniser: entrada[i] passes through SYNC_STAGES flops. The last stage is sync[i].
- Debounce, per channel, at each edge:
  - If sync == nivel, the counter goes to 0.
  - Otherwise, if counter == DEBOUNCE−1, then nivel <= sync and counter <= 0; else counter increments.
  - The counter width is $clog2(DEBOUNCE)+1, and the counter never wraps.
- Edge classification happens at the nivel update. A 0→1 update is a rising edge; a 1→0 update is a falling edge.
- detector[i] is driven high for exactly one cycle when the classified edge is enabled by modo[i]. In mode 00 it never pulses, but nivel still tracks the input.
- Pending/overflow update, per channel, at each edge, with ev = the enabled edge being registered into detector this edge:
  - ev and ack: pendente <= 1, overflow <= 0.
  - ev, no ack, pendente == 1: overflow <= 1, pendente stays 1.
  - ev, no ack, pendente == 0: pendente <= 1.
  - ack, no ev: pendente <= 0, overflow <= 0.
- Changing modo affects only edges classified at later clock edges. It never clears pendente or overflow.
- After reset, nivel is 0. An input held high through reset therefore produces a rising event once it has passed the synchroniser and debounce.

## Timing

- Latency: entrada changes and is stable from clock edge 0.
  - nivel and detector change after edge SYNC_STAGES+DEBOUNCE (defaults: edge 6).
  - pendente sets at that same edge.
  - irq follows pendente combinationally, with no added cycle.
- Glitch rejection: a pulse on sync shorter than DEBOUNCE cycles never changes nivel and never produces an event.
- Separate edges: two accepted edges on one channel are at least DEBOUNCE cycles apart, so detector pulses on one channel are never adjacent when DEBOUNCE ≥ 2.
- Reset mid-operation: partial debounce counts are discarded and no event is emitted for the interrupted transition.
- Channel independence: channels are fully independent. Simultaneous events on several channels each set their own flags in the same cycle.

## Structure

- Shared package detector_borda_pkg holds the mode constants MODO_OFF=2'b00, MODO_SUBIDA=2'b01, MODO_DESCIDA=2'b10 and MODO_AMBAS=2'b11.
- Sub-module canal_debounce holds one channel's synchroniser, debounce counter, nivel register and edge classification. It outputs the rising/falling strobes and nivel. The top level instantiates it CANAIS times in a generate loop.
- pendente, overflow, detector gating and irq stay in the top level.

## Test plan

- Clean rising edge: defaults, modo[1:0]=01, entrada[0] 0→1 held. Required: detector[0] pulses once after edge 6, pendente[0]=1, irq=1, nivel[0]=1; no event on the later 1→0 transition.
- Glitch rejection: entrada[2] high for 3 cycles, DEBOUNCE=4. Required: nivel[2] stays 0, no detector pulse, pendente stays 0.
- Both-edges mode with overflow: modo[7:6]=11, entrada[3] toggled with 10-cycle stable periods, no ack. Required: a pulse on every toggle; overflow[3]=1 after the second event.
- Ack collision: an event and ack[5]=1 in the same cycle while pendente[5]=1 and overflow[5]=1. Required: pendente[5]=1, overflow[5]=0; a subsequent lone ack gives pendente[5]=0 and irq=0.
- Reset mid-debounce: entrada[1] high, rst pulsed 2 cycles after sync changes, input held high. Required: all outputs 0 after reset; one rising event exactly SYNC_STAGES+DEBOUNCE edges after rst deasserts.
- Mode off, multi-channel: modo=0 with all entrada toggling. Required: nivel follows the inputs after the latency; detector, pendente and irq remain 0.
